// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: occupancy width,
// state encoding and the payload layout stages use to pack/unpack fields.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_st_e;

  // ID/EX payload layout, LSB first
  localparam int IDEX_CTRL_LSB   = 0;
  localparam int IDEX_CTRL_W     = 8;
  localparam int IDEX_ALUOP_LSB  = 8;
  localparam int IDEX_ALUOP_W    = 4;
  localparam int IDEX_SA_LSB     = 12;
  localparam int IDEX_SA_W       = 5;
  localparam int IDEX_RD_LSB     = 17;
  localparam int IDEX_RT_LSB     = 22;
  localparam int IDEX_RS_LSB     = 27;
  localparam int IDEX_REG_W      = 5;
  localparam int IDEX_SIGEXT_LSB = 32;
  localparam int IDEX_RDATA2_LSB = 64;
  localparam int IDEX_RDATA1_LSB = 96;
  localparam int IDEX_WORD_W     = 32;
  localparam int IDEX_W          = 128;

  function automatic logic [OCC_W-1:0] occ_of(input logic m, input logic s);
    return {1'b0, m} + {1'b0, s};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/payload channel between pipeline stages.
interface pipe_stage_reg_if #(parameter int DATA_W = 32);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_slot.sv
// One storage slot: payload register plus valid bit. clr squashes the slot
// (and optionally the payload) with priority over the load.
module pipe_skid_slot #(
  parameter int DATA_W      = 32,
  parameter bit CLR_PAYLOAD = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld,
  input  logic              vld_nxt,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              vld
);

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      vld <= 1'b0;
      if (CLR_PAYLOAD) q <= '0;
    end else begin
      vld <= vld_nxt;
      if (ld) q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register with optional 2-entry skid buffer and
// synchronous flush. M drives the output; S catches the item accepted while stalled.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter bit SKID        = 1'b1,
  parameter bit CLR_PAYLOAD = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_st_e          st, st_n;
  logic              m_vld, s_vld, m_vn, s_vn;
  logic              m_ld, s_ld, m_from_s;
  logic              acc, con;
  logic [DATA_W-1:0] m_q, s_q, m_d;

  assign acc       = up.valid & up.ready;
  assign con       = m_vld & dn.ready;
  assign m_d       = m_from_s ? s_q : up.data;
  assign dn.valid  = m_vld;
  assign dn.data   = m_q;

  pipe_skid_slot #(.DATA_W(DATA_W), .CLR_PAYLOAD(CLR_PAYLOAD)) u_m (
    .clock, .reset, .clr(flush), .ld(m_ld), .vld_nxt(m_vn),
    .d(m_d), .q(m_q), .vld(m_vld)
  );

  generate
    if (SKID) begin : g_skid
      // ready depends only on the skid flop, never on dn.ready
      assign up.ready = !s_vld;
      pipe_skid_slot #(.DATA_W(DATA_W), .CLR_PAYLOAD(CLR_PAYLOAD)) u_s (
        .clock, .reset, .clr(flush), .ld(s_ld), .vld_nxt(s_vn),
        .d(up.data), .q(s_q), .vld(s_vld)
      );
    end else begin : g_noskid
      assign up.ready = !m_vld | dn.ready;
      assign s_q      = '0;
      assign s_vld    = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      st        <= ST_EMPTY;
      occupancy <= '0;
    end else begin
      st        <= st_n;
      occupancy <= occ_of(m_vn, s_vn);
    end
  end

  // Without a skid slot, accepting in ONE implies consuming, so FULL is unreachable.
  always_comb begin
    st_n     = st;
    m_ld     = 1'b0;
    s_ld     = 1'b0;
    m_from_s = 1'b0;
    m_vn     = m_vld;
    s_vn     = s_vld;
    case (st)
      ST_EMPTY: if (acc) begin
        st_n = ST_ONE;
        m_ld = 1'b1;
        m_vn = 1'b1;
      end
      ST_ONE: begin
        if (acc && con) begin
          m_ld = 1'b1;
        end else if (acc) begin
          st_n = ST_FULL;
          s_ld = 1'b1;
          s_vn = 1'b1;
        end else if (con) begin
          st_n = ST_EMPTY;
          m_vn = 1'b0;
        end
      end
      ST_FULL: if (con) begin
        st_n     = ST_ONE;
        m_ld     = 1'b1;
        m_from_s = 1'b1;
        s_vn     = 1'b0;
      end
      default: begin
        st_n = ST_EMPTY;
        m_vn = 1'b0;
        s_vn = 1'b0;
      end
    endcase
  end

  a_occ_max:   assert property (@(posedge clock) occupancy <= 2'd2);
  a_s_needs_m: assert property (@(posedge clock) !(s_vld && !m_vld));
  a_stall:     assert property (@(posedge clock)
                 (reset && !flush && m_vld && !dn.ready) |=> $stable(m_q));

endmodule
